// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default widths, the FSM state
// encoding, and the read-latency counter sizing helper.
package load_store_unit_pkg;

    localparam int LSU_DATA_W     = 16;
    localparam int LSU_MEM_DEPTH  = 256;
    localparam int LSU_RD_LATENCY = 0;
    localparam int LSU_ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // A zero-latency memory still needs a 1-bit counter to keep the declaration legal.
    function automatic int cnt_width(input int latency);
        return (latency > 0) ? $clog2(latency + 1) : 1;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Data-memory initiator for the 16-bit core: one request at a time, registered
// memory strobes, range-checked addresses and a valid/ready response channel.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W     = LSU_DATA_W,
    parameter int MEM_DEPTH  = LSU_MEM_DEPTH,
    parameter int RD_LATENCY = LSU_RD_LATENCY,
    parameter int ERR_CNT_W  = LSU_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DATA_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic [DATA_W-1:0]    mem_access_addr,
    output logic [DATA_W-1:0]    mem_write_data,
    input  logic [DATA_W-1:0]    mem_read_data,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = cnt_width(RD_LATENCY);

    lsu_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic                 write_en_next;
    logic                 read_en_next;
    logic [DATA_W-1:0]    addr_next;
    logic [DATA_W-1:0]    wdata_next;
    logic                 rsp_valid_next;
    logic                 rsp_err_next;
    logic [DATA_W-1:0]    rsp_rdata_next;
    logic [ERR_CNT_W-1:0] err_count_next;
    logic                 addr_err;

    // Widened compare so MEM_DEPTH == 2**DATA_W never flags an error.
    assign addr_err  = (32'(req_addr) >= MEM_DEPTH);
    assign req_ready = (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            mem_write_en    <= 1'b0;
            mem_read_en     <= 1'b0;
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_rdata       <= '0;
            err_count       <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            mem_write_en    <= write_en_next;
            mem_read_en     <= read_en_next;
            mem_access_addr <= addr_next;
            mem_write_data  <= wdata_next;
            rsp_valid       <= rsp_valid_next;
            rsp_err         <= rsp_err_next;
            rsp_rdata       <= rsp_rdata_next;
            err_count       <= err_count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (addr_err)    state_next = ST_RESP;
                    else if (req_we) state_next = ST_WRITE;
                    else             state_next = ST_READ;
                end
            end
            ST_WRITE: state_next = ST_RESP;
            ST_READ:  if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Enables default low, so each strobe lasts only as long as its state asserts it.
    always_comb begin
        write_en_next  = 1'b0;
        read_en_next   = 1'b0;
        addr_next      = mem_access_addr;
        wdata_next     = mem_write_data;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid;
        rsp_err_next   = rsp_err;
        rsp_rdata_next = rsp_rdata;
        err_count_next = err_count;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (addr_err) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                        if (err_count != {ERR_CNT_W{1'b1}})
                            err_count_next = err_count + ERR_CNT_W'(1);
                    end else if (req_we) begin
                        write_en_next = 1'b1;
                        addr_next     = req_addr;
                        wdata_next    = req_wdata;
                    end else begin
                        read_en_next = 1'b1;
                        addr_next    = req_addr;
                        cnt_next     = CNT_W'(RD_LATENCY);
                    end
                end
            end
            ST_WRITE: begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_rdata_next = '0;
            end
            ST_READ: begin
                if (cnt_reg == '0) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = mem_read_data;
                end else begin
                    read_en_next = 1'b1;
                    cnt_next     = cnt_reg - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) rsp_valid_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two LSUs (read latency 0 and 2) each driving a behavioural
// data memory, checked with immediate assertions against hand-computed values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT A: RD_LATENCY = 0
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic        mem_write_en, mem_read_en;
    logic [15:0] req_addr, req_wdata, rsp_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic [7:0]  err_count;

    // DUT B: RD_LATENCY = 2
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic        b_mem_write_en, b_mem_read_en;
    logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_mem_access_addr, b_mem_write_data, b_mem_read_data;
    logic [7:0]  b_err_count;

    load_store_unit #(.DATA_W(16), .MEM_DEPTH(256), .RD_LATENCY(0), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .err_count(err_count)
    );

    load_store_unit #(.DATA_W(16), .MEM_DEPTH(256), .RD_LATENCY(2), .ERR_CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_write_en(b_mem_write_en), .mem_read_en(b_mem_read_en),
        .mem_access_addr(b_mem_access_addr), .mem_write_data(b_mem_write_data),
        .mem_read_data(b_mem_read_data), .err_count(b_err_count)
    );

    // Memory A: combinational read; memory B: two-cycle read pipeline.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] b_d1, b_d2;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
    end

    always @(posedge clk) if (mem_write_en) mem_a[mem_access_addr[7:0]] <= mem_write_data;
    assign mem_read_data = mem_read_en ? mem_a[mem_access_addr[7:0]] : 16'h0;

    always @(posedge clk) begin
        if (b_mem_write_en) mem_b[b_mem_access_addr[7:0]] <= b_mem_write_data;
        b_d1 <= b_mem_read_en ? mem_b[b_mem_access_addr[7:0]] : 16'h0;
        b_d2 <= b_d1;
    end
    assign b_mem_read_data = b_d2;

    // Enable-cycle counters and the write/read exclusivity check.
    int we_cnt = 0, re_cnt = 0, b_re_cnt = 0;
    always @(negedge clk) begin
        if (mem_write_en)  we_cnt++;
        if (mem_read_en)   re_cnt++;
        if (b_mem_read_en) b_re_cnt++;
        if (rst_n === 1'b1) begin
            tests++;
            assert (!(mem_write_en && mem_read_en) && !(b_mem_write_en && b_mem_read_en)) else begin
                fails++;
                $error("FAIL excl: write_en=%0b read_en=%0b b_write_en=%0b b_read_en=%0b expected not both high",
                       mem_write_en, mem_read_en, b_mem_write_en, b_mem_read_en);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on DUT A with rsp_ready high; exp_lat counts cycles after the accept edge.
    task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int n;
        int we0;
        int re0;
        we0 = we_cnt;
        re0 = re_cnt;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        tick();
        chk({tag, "_rsp_done"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_we_cycles"}, 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
        chk({tag, "_re_cycles"}, 32'(re_cnt - re0), (!we && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int n;
        int re0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        #25;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_enables", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("reset_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: store then load the same word
        do_req("t1_store5", 1'b1, 16'd5, 16'd50, 16'd0, 1'b0, 1);
        do_req("t1_load5", 1'b0, 16'd5, 16'd0, 16'd50, 1'b0, 1);

        // 2: out-of-range load, then top valid address
        do_req("t2_load300", 1'b0, 16'd300, 16'd0, 16'd0, 1'b1, 0);
        chk("t2_err_count", 32'(err_count), 32'd1);
        do_req("t2_store255", 1'b1, 16'd255, 16'hBEEF, 16'd0, 1'b0, 1);
        do_req("t2_load255", 1'b0, 16'd255, 16'd0, 16'hBEEF, 1'b0, 1);
        do_req("t2_store256", 1'b1, 16'd256, 16'h1111, 16'd0, 1'b1, 0);
        chk("t2_err_count2", 32'(err_count), 32'd2);

        // 3: back-pressure on the response channel
        do_req("t3_store2", 1'b1, 16'd2, 16'h0ABC, 16'd0, 1'b0, 1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd2;
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd9; req_wdata = 16'h0099;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t3_hold_rdata", 32'(rsp_rdata), 32'h0ABC);
            chk("t3_hold_req_ready", 32'(req_ready), 32'd0);
            chk("t3_hold_no_write", 32'(mem_write_en), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_after_hs_valid", 32'(rsp_valid), 32'd0);
        chk("t3_after_hs_ready", 32'(req_ready), 32'd1);
        tick();
        chk("t3_second_accepted", 32'(mem_write_en), 32'd1);
        req_valid = 1'b0;
        tick();
        tick();
        do_req("t3_load9", 1'b0, 16'd9, 16'd0, 16'h0099, 1'b0, 1);

        // 4: back-to-back stores then loads
        for (int i = 0; i < 4; i++)
            do_req("t4_store", 1'b1, 16'(i), 16'(10 * (i + 1)), 16'd0, 1'b0, 1);
        for (int i = 0; i < 4; i++)
            do_req("t4_load", 1'b0, 16'(i), 16'd0, 16'(10 * (i + 1)), 1'b0, 1);

        // 5: asynchronous reset during WRITE
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd10; req_wdata = 16'd99;
        tick();
        req_valid = 1'b0;
        chk("t5_in_write", 32'(mem_write_en), 32'd1);
        #5 rst_n = 1'b0;
        #1;
        chk("t5_write_en_drop", 32'(mem_write_en), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd1);
        chk("t5_err_count", 32'(err_count), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        do_req("t5_load5_after", 1'b0, 16'd5, 16'd0, 16'd50, 1'b0, 1);

        // 6: RD_LATENCY = 2 instance
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'd7; b_req_wdata = 16'h1234;
        tick();
        b_req_valid = 1'b0;
        tick();
        chk("t6_store_rsp", 32'(b_rsp_valid), 32'd1);
        tick();
        re0 = b_re_cnt;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'd7;
        tick();
        b_req_valid = 1'b0;
        chk("t6_read_en", 32'(b_mem_read_en), 32'd1);
        n = 0;
        while (!b_rsp_valid && n < 16) begin
            tick();
            n++;
        end
        chk("t6_latency", 32'(n), 32'd3);
        chk("t6_rdata", 32'(b_rsp_rdata), 32'h1234);
        chk("t6_err", 32'(b_rsp_err), 32'd0);
        tick();
        chk("t6_re_cycles", 32'(b_re_cnt - re0), 32'd3);
        chk("t6_idle", 32'(b_req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
